// File: rtl/ram_copy_engine_if.sv
// rtl/ram_copy_engine_if.sv - RAM port bundle between the copy engine (master) and a single-port RAM (slave)
interface ram_copy_engine_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
   modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/ram_copy_engine.sv
// rtl/ram_copy_engine.sv - byte-wise RAM-to-RAM block copy master; optional write checksum under RAM_COPY_CSUM_EN
module ram_copy_engine #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
`ifdef RAM_COPY_CSUM_EN
   output logic [DATA_W-1:0] csum,
`endif
   ram_copy_engine_if.master ram
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WAIT,
      S_WR,
      S_DONE
   } state_t;

   localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [1:0]      WAIT_INIT = 2'(RD_LAT - 1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [ADDR_W:0]   r_cnt;
   logic [ADDR_W:0]   r_idx;
   logic [1:0]        r_wait;
   logic              r_busy;
   logic              r_done;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
`ifdef RAM_COPY_CSUM_EN
   logic [DATA_W-1:0] r_csum;
`endif

   logic [ADDR_W:0]   w_len_sat;
   logic [ADDR_W:0]   w_idx_next;

   assign w_len_sat  = (len > DEPTH) ? DEPTH : len;
   assign w_idx_next = r_idx + 1'b1;

   // All outputs are registered: each transition loads the values the next state presents.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_src   <= '0;
         r_dst   <= '0;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_wait  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
`ifdef RAM_COPY_CSUM_EN
         r_csum  <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         r_we   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_src  <= src_addr;
                  r_dst  <= dst_addr;
                  r_cnt  <= w_len_sat;
                  r_idx  <= '0;
                  r_busy <= 1'b1;
`ifdef RAM_COPY_CSUM_EN
                  r_csum <= '0;
`endif
                  if (w_len_sat == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= S_RD;
                     r_addr  <= src_addr;
                  end
               end
            end
            S_RD: begin
               r_state <= S_WAIT;
               r_wait  <= WAIT_INIT;
            end
            S_WAIT: begin
               // RAM data for the RD address is valid in the last WAIT cycle.
               if (r_wait == '0) begin
                  r_state <= S_WR;
                  r_wdata <= ram.mem_rdata;
                  r_addr  <= r_dst + r_idx[ADDR_W-1:0];
                  r_we    <= 1'b1;
               end else begin
                  r_wait <= r_wait - 1'b1;
               end
            end
            S_WR: begin
               r_idx <= w_idx_next;
`ifdef RAM_COPY_CSUM_EN
               r_csum <= r_csum ^ r_wdata;
`endif
               if (w_idx_next == r_cnt) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_RD;
                  r_addr  <= r_src + w_idx_next[ADDR_W-1:0];
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign ram.mem_we    = r_we;
   assign ram.mem_addr  = r_addr;
   assign ram.mem_wdata = r_wdata;
`ifdef RAM_COPY_CSUM_EN
   assign csum          = r_csum;
`endif

endmodule
